// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the transmit path and by future receive-side blocks.
package uart_pkg;
  localparam int UART_BYTE_W             = 8;
  localparam int UART_TX_FIFO_DEPTH_LOG2 = 4;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-write and transmitter-handshake bundle for the UART transmit FIFO.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_TX_FIFO_DEPTH_LOG2
);
  logic                wr_en;
  uart_byte_t          wr_data;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                clr_overflow;
  logic                tx_ready;
  uart_byte_t          txdata;
  logic                tx_enable;

  // Master is the host plus transmitter side; slave is the FIFO itself.
  modport master (
    output wr_en, wr_data, clr_overflow, tx_ready,
    input  full, empty, count, overflow, txdata, tx_enable
  );

  modport slave (
    input  wr_en, wr_data, clr_overflow, tx_ready,
    output full, empty, count, overflow, txdata, tx_enable
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port byte array: synchronous write, asynchronous read. Contents are never reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_TX_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  uart_byte_t            wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output uart_byte_t            rdata
);
  uart_byte_t mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: buffers host writes and issues one-cycle
// tx_enable requests whenever the transmitter reports ready.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_TX_FIFO_DEPTH_LOG2
) (
  input  logic         clk,
  input  logic         reset_,
  uart_tx_fifo_if.slave bus
);
  localparam int                  DEPTH     = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  tx_enable;
  uart_byte_t            txdata;
  uart_byte_t            rd_data;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign push  = bus.wr_en && !full;
  // Blocking on tx_enable stops a double issue while the transmitter still shows ready during its sample cycle.
  assign pop   = bus.tx_ready && !empty && !tx_enable;

  uart_fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(bus.wr_data),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      tx_enable <= 1'b0;
      txdata    <= '0;
    end else begin
      tx_enable <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        txdata <= rd_data;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.wr_en && full)  overflow <= 1'b1;
      else if (bus.clr_overflow) overflow <= 1'b0;
    end
  end

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
  assign bus.txdata    = txdata;
  assign bus.tx_enable = tx_enable;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a byte scoreboard and a simple transmitter model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset_;
  int   vecs = 0;
  int   errs = 0;
  int   rx_cnt = 0;
  int   mode = 0;        // 0: tx_ready low, 1: tx_ready high, 2: transmitter model
  int   model_n = 3;
  logic model_rdy = 1'b1;
  int   busy = 0;
  logic drop_pend = 1'b0;
  logic prev_en = 1'b0;
  uart_byte_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH_LOG2(4)) bus();

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk   (clk),
    .reset_(reset_),
    .bus   (bus)
  );

  assign bus.tx_ready = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : model_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input uart_byte_t b, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Transmitter side: samples txdata on tx_enable, then (in model mode) goes busy for model_n cycles.
  always @(posedge clk) begin
    #2;
    if (!reset_) begin
      model_rdy = 1'b1;
      busy      = 0;
      drop_pend = 1'b0;
      prev_en   = 1'b0;
    end else begin
      if (drop_pend) begin
        model_rdy = 1'b0;
        busy      = model_n;
        drop_pend = 1'b0;
      end else if (!model_rdy) begin
        if (busy > 0) busy--;
        if (busy == 0) model_rdy = 1'b1;
      end
      if (bus.tx_enable === 1'b1) begin
        check("tx_enable_single_cycle", {31'd0, prev_en}, 32'd0);
        check("tx_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          check("txdata_order", {24'd0, bus.txdata}, {24'd0, exp_q.pop_front()});
          rx_cnt++;
        end
        if (mode == 2) drop_pend = 1'b1;
      end
      prev_en = bus.tx_enable;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int next;
    int cyc;
    reset_           = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_data      = '0;
    bus.clr_overflow = 1'b0;
    mode             = 0;
    repeat (3) @(negedge clk);
    check("rst_hold_tx_enable", {31'd0, bus.tx_enable}, 32'd0);
    check("rst_hold_empty", {31'd0, bus.empty}, 32'd1);
    reset_ = 1'b1;
    @(negedge clk);
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_count", {27'd0, bus.count}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check("rst_tx_enable", {31'd0, bus.tx_enable}, 32'd0);
    check("rst_txdata", {24'd0, bus.txdata}, 32'h00);

    // Single byte with transmitter always ready
    mode = 1;
    wr(8'h55, 1'b1);
    check("single_count_after_w", {27'd0, bus.count}, 32'd1);
    check("single_no_early_issue", {31'd0, bus.tx_enable}, 32'd0);
    @(negedge clk);
    check("single_tx_enable", {31'd0, bus.tx_enable}, 32'd1);
    check("single_txdata", {24'd0, bus.txdata}, 32'h55);
    check("single_count_after_pop", {27'd0, bus.count}, 32'd0);
    @(negedge clk);
    check("single_tx_enable_drop", {31'd0, bus.tx_enable}, 32'd0);
    check("single_empty", {31'd0, bus.empty}, 32'd1);
    check("single_txdata_hold", {24'd0, bus.txdata}, 32'h55);

    // Fill and overflow with transmitter stalled
    mode = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) wr(uart_byte_t'(i), 1'b1);
    check("fill_full", {31'd0, bus.full}, 32'd1);
    check("fill_count", {27'd0, bus.count}, 32'd16);
    check("fill_no_overflow", {31'd0, bus.overflow}, 32'd0);
    wr(8'hAA, 1'b0);
    check("ovf_set", {31'd0, bus.overflow}, 32'd1);
    check("ovf_count_held", {27'd0, bus.count}, 32'd16);
    bus.clr_overflow = 1'b1;
    wr(8'hBB, 1'b0);
    bus.clr_overflow = 1'b0;
    check("ovf_set_wins", {31'd0, bus.overflow}, 32'd1);
    bus.clr_overflow = 1'b1;
    @(negedge clk);
    bus.clr_overflow = 1'b0;
    check("ovf_cleared", {31'd0, bus.overflow}, 32'd0);
    check("ovf_count_after_clr", {27'd0, bus.count}, 32'd16);

    // Drain through the transmitter model while topping up across the pointer wrap
    rx_cnt = 0;
    mode   = 2;
    next   = 8'h10;
    cyc    = 0;
    while (next <= 8'h17 && cyc < 2000) begin
      if (!bus.full) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = uart_byte_t'(next);
        exp_q.push_back(uart_byte_t'(next));
        next++;
      end else begin
        bus.wr_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.wr_en = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    check("drain_no_timeout", {31'd0, cyc < 2000}, 32'd1);
    check("drain_rx_count", rx_cnt, 32'd24);
    check("drain_count_zero", {27'd0, bus.count}, 32'd0);
    check("drain_empty", {31'd0, bus.empty}, 32'd1);
    mode = 0;
    repeat (model_n + 2) @(negedge clk);

    // Simultaneous write and pop at count 3
    wr(8'hA0, 1'b1);
    wr(8'hA1, 1'b1);
    wr(8'hA2, 1'b1);
    check("simul_pre_count", {27'd0, bus.count}, 32'd3);
    mode = 1;
    wr(8'hA3, 1'b1);
    mode = 0;
    check("simul_count_held", {27'd0, bus.count}, 32'd3);
    check("simul_tx_enable", {31'd0, bus.tx_enable}, 32'd1);
    check("simul_txdata", {24'd0, bus.txdata}, 32'hA0);
    mode = 1;
    cyc  = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    check("simul_drain_no_timeout", {31'd0, cyc < 50}, 32'd1);
    check("simul_count_zero", {27'd0, bus.count}, 32'd0);

    // Reset while a request is outstanding
    mode = 0;
    for (int i = 0; i < 6; i++) wr(uart_byte_t'(8'hC0 + i), 1'b1);
    mode = 1;
    @(negedge clk);
    mode = 0;
    check("midrst_pre_count", {27'd0, bus.count}, 32'd5);
    check("midrst_pre_tx_enable", {31'd0, bus.tx_enable}, 32'd1);
    #1 reset_ = 1'b0;
    #1;
    check("midrst_tx_enable_drop", {31'd0, bus.tx_enable}, 32'd0);
    check("midrst_count_clear", {27'd0, bus.count}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_ = 1'b1;
    mode   = 1;
    repeat (6) @(negedge clk);
    check("postrst_count", {27'd0, bus.count}, 32'd0);
    check("postrst_empty", {31'd0, bus.empty}, 32'd1);
    check("postrst_tx_enable", {31'd0, bus.tx_enable}, 32'd0);
    wr(8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    check("postrst_new_byte_sent", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-wide transmit FIFO that sits directly upstream of the UART transmitter.
- Accepts bytes from a host write port and buffers them.
- Drains them one at a time into the transmitter over its txdata / tx_enable / tx_ready handshake, so the host is decoupled from baud-rate timing.
- Reports occupancy and a sticky overflow flag.

Parameters:
- DEPTH_LOG2, 4: log2 of FIFO depth; depth = 2**DEPTH_LOG2 (16 by default), legal range 1..8.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_  input  1  reset, asynchronous, active-low
- wr_en  input  1  host write strobe; wr_data is captured when sampled high
- wr_data  input  8  byte to enqueue
- full  output  1  FIFO holds 2**DEPTH_LOG2 bytes
- empty  output  1  FIFO holds 0 bytes
- count  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
- overflow  output  1  sticky; set when a write is attempted while full
- clr_overflow  input  1  synchronous clear of overflow
- tx_ready  input  1  from transmitter; high when idle and able to accept a byte
- txdata  output  8  byte presented to transmitter
- tx_enable  output  1  one-cycle request; transmitter samples txdata when tx_enable && tx_ready

Behaviour:
- Reset (async, reset_ low):
  - rd_ptr, wr_ptr and count are cleared to 0, so empty=1, full=0.
  - overflow=0, tx_enable=0, txdata=8'h00.
  - Memory contents are not reset.
  - Reset mid-transfer drops all queued bytes and deasserts tx_enable immediately.
- Storage and flags:
  - Circular buffer with read and write pointers of DEPTH_LOG2 bits, wrapping modulo depth.
  - count is a registered counter.
  - full = (count == 2**DEPTH_LOG2); empty = (count == 0); both decoded from registered count.
- Write:
  - When wr_en=1 and full=0: mem[wr_ptr] <= wr_data, wr_ptr increments and wraps.
  - When wr_en=1 and full=1: the byte is dropped, pointers and count are unchanged, overflow <= 1.
  - full is evaluated on the pre-edge state. A write while full is dropped even if a pop occurs in the same cycle.
- Issue (pop):
  - Condition: tx_ready=1, empty=0, tx_enable=0.
  - On that edge: txdata <= mem[rd_ptr], tx_enable <= 1, rd_ptr increments and wraps; this counts as the pop.
- Request timing:
  - tx_enable is high for exactly one cycle and then returns to 0 unconditionally.
  - The tx_enable=0 term in the issue condition prevents a second issue in the cycle where the transmitter is still showing tx_ready=1 while sampling.
  - The transmitter drops tx_ready on the following cycle.
  - The next issue waits until tx_ready returns high.
- txdata holds its last value between issues.
- Count update:
  - Write only: +1. Pop only: −1. Write and pop in the same cycle: unchanged.
  - Never exceeds depth; never goes below 0.
- Latency:
  - Into an empty FIFO with tx_ready=1, a byte written on edge W sees count=1 after W.
  - It is issued on edge W+1, so tx_enable=1 during the cycle after W+1.
  - count returns to 0 after W+1.
- Back-to-back transmission: the next issue occurs on the first edge where tx_ready=1 and tx_enable=0 while the FIFO is non-empty. No bubbles beyond those imposed by the handshake.
- overflow:
  - Set by a dropped write; cleared by clr_overflow.
  - If set and clear occur in the same cycle, set wins.
- Ordering: strict FIFO; bytes are issued in write order across pointer wrap.

Decomposition:
- Shared package uart_pkg:
  - UART_BYTE_W = 8.
  - Default FIFO depth constant UART_TX_FIFO_DEPTH_LOG2 = 4.
- One sub-module is natural: uart_fifo_mem.
  - Simple dual-port register array, 8 bits wide, 2**DEPTH_LOG2 entries.
  - One synchronous write port and one asynchronous read port.
  - Reusable by a future receive FIFO.
- Pointers, count, flags and the issue logic stay in uart_tx_fifo.

Test Plan:
- Reset: release reset_ → empty=1, full=0, count=0, overflow=0, tx_enable=0, txdata=8'h00.
- Single byte, tx_ready held 1: write 8'h55 on edge W → tx_enable high for exactly one cycle after edge W+1 with txdata=8'h55; count 1 then 0; empty=1 afterwards.
- Fill/overflow, tx_ready held 0:
  - Write 8'h00..8'h0F → full=1, count=16.
  - 17th write of 8'hAA → overflow=1, count stays 16.
  - Pulse clr_overflow → overflow=0.
- Drain order with wrap: from the full state, model the transmitter (tx_ready drops the cycle after each sample, returns after N cycles) while writing 8'h10..8'h17 as space frees → transmitter receives 8'h00..8'h17 in order, each tx_enable exactly one cycle, never two consecutive.
- Simultaneous write and pop with count=3 → count remains 3; written byte appears after the existing 3 in the output order.
- Reset mid-operation: with count=5 and tx_enable high, assert reset_ → tx_enable drops immediately; after release count=0, no further tx_enable until new writes occur.
